// File: rtl/uart_echo_fifo_ctrl.sv
// Buffered UART echo: RX core -> per-byte transform -> FIFO -> TX core.
// RX and TX FSMs run independently; bytes arriving on a full FIFO are dropped and counted.
`timescale 1ns/1ps
module uart_echo_fifo_ctrl #(
    parameter int unsigned        DATA_W  = 8,
    parameter int unsigned        DEPTH   = 16,
    parameter int unsigned        ADDR_W  = 4,
    parameter logic [DATA_W-1:0]  XOR_KEY = 8'h20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic              clr_ovf,
    input  logic              rx_done,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_en_sig,
    input  logic              tx_done,
    output logic              tx_en_sig,
    output logic [DATA_W-1:0] tx_data,
    output logic [ADDR_W:0]   fifo_level,
    output logic              ovf_flag,
    output logic [7:0]        ovf_cnt
);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ARM  = 2'd1;
    localparam logic [1:0] R_GAP  = 2'd2;

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_SEND = 2'd1;
    localparam logic [1:0] T_GAP  = 2'd2;

    localparam logic [ADDR_W:0]   L_FULL    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   L_LVL_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] L_PTR_ONE = ADDR_W'(1);
    localparam logic [DATA_W-1:0] L_DAT_ONE = DATA_W'(1);

    logic [1:0]        r_rx_state;
    logic [1:0]        w_rx_next;
    logic [1:0]        r_tx_state;
    logic [1:0]        w_tx_next;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_ovf_flag;
    logic [7:0]        r_ovf_cnt;

    logic              w_full;
    logic              w_empty;
    logic              w_discard;
    logic              w_push;
    logic              w_pop;
    logic              w_drop_ovf;
    logic              w_load;
    logic [DATA_W-1:0] w_xform;

    assign w_full     = (r_level == L_FULL);
    assign w_empty    = (r_level == '0);
    assign w_discard  = (mode == 2'b11);
    // A full FIFO drops the byte even if TX pops on the same edge.
    assign w_push     = rx_done && !w_discard && !w_full;
    assign w_drop_ovf = rx_done && !w_discard && w_full;
    assign w_pop      = (r_tx_state == T_SEND) && tx_done;
    assign w_load     = (r_tx_state == T_IDLE) && !w_empty;

    always_comb begin
        w_xform = rx_data;
        case (mode)
            2'b01:   w_xform = rx_data ^ XOR_KEY;
            2'b10:   w_xform = rx_data + L_DAT_ONE;
            default: w_xform = rx_data;
        endcase
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            R_IDLE: if (enable && !w_full) w_rx_next = R_ARM;
            R_ARM: begin
                if (rx_done)
                    w_rx_next = R_GAP;
                else if (!enable || w_full)
                    w_rx_next = R_IDLE;
            end
            R_GAP:   w_rx_next = (enable && !w_full) ? R_ARM : R_IDLE;
            default: w_rx_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            T_IDLE:  if (!w_empty) w_tx_next = T_SEND;
            T_SEND:  if (tx_done) w_tx_next = T_GAP;
            T_GAP:   w_tx_next = T_IDLE;
            default: w_tx_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= R_IDLE;
            r_tx_state <= T_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_tx_data  <= '0;
        end else begin
            r_rx_state <= w_rx_next;
            r_tx_state <= w_tx_next;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + L_LVL_ONE;
                2'b01:   r_level <= r_level - L_LVL_ONE;
                default: r_level <= r_level;
            endcase
            if (w_load)
                r_tx_data <= r_mem[r_rd_ptr];
        end
    end

    // Storage is not reset: only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_xform;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_flag <= 1'b0;
            r_ovf_cnt  <= '0;
        end else if (clr_ovf) begin
            r_ovf_flag <= 1'b0;
            r_ovf_cnt  <= '0;
        end else if (w_drop_ovf) begin
            r_ovf_flag <= 1'b1;
            if (r_ovf_cnt != '1)
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign rx_en_sig  = (r_rx_state == R_ARM);
    assign tx_en_sig  = (r_tx_state == T_SEND);
    assign tx_data    = r_tx_data;
    assign fifo_level = r_level;
    assign ovf_flag   = r_ovf_flag;
    assign ovf_cnt    = r_ovf_cnt;

endmodule
